// File: rtl/inc_share_arbiter_if.sv
// Request/ack/count bundle for the two-channel shared-incrementer counter.
// The bench drives the request side; the counter block is the slave.
interface inc_share_arbiter_if;
    logic       req0;
    logic       req1;
    logic       clr0;
    logic       clr1;
    logic       ack0;
    logic       ack1;
    logic [3:0] cnt0;
    logic [3:0] cnt1;
    logic       wrap0;
    logic       wrap1;
    logic       busy;

    modport master (
        output req0, req1, clr0, clr1,
        input  ack0, ack1, cnt0, cnt1, wrap0, wrap1, busy
    );

    modport slave (
        input  req0, req1, clr0, clr1,
        output ack0, ack1, cnt0, cnt1, wrap0, wrap1, busy
    );
endinterface

// File: rtl/inc_share_arbiter.sv
// Two 4-bit event counters sharing one incrementer, granted round-robin.
// A channel whose ack is high is ineligible, so a held req counts once per ack.
module Inc4Bit (
    input  logic [3:0] a,
    output logic [3:0] b
);
    assign b[0] = ~a[0];
    assign b[1] = a[1] ^ a[0];
    assign b[2] = a[2] ^ (a[1] & a[0]);
    assign b[3] = a[3] ^ (&a[2:0]);
endmodule

module inc_share_arbiter #(
    parameter bit SAT   = 1'b0,
    parameter bit FIRST = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    inc_share_arbiter_if.slave bus
);
    logic [3:0] r_cnt0;
    logic [3:0] r_cnt1;
    logic       r_ack0;
    logic       r_ack1;
    logic       r_wrap0;
    logic       r_wrap1;
    logic       r_ptr;

    logic       w_elig0;
    logic       w_elig1;
    logic       w_gnt0;
    logic       w_gnt1;
    logic [3:0] w_sel;
    logic [3:0] w_inc;
    logic       w_top0;
    logic       w_top1;

    assign w_elig0 = bus.req0 & ~r_ack0 & ~bus.clr0;
    assign w_elig1 = bus.req1 & ~r_ack1 & ~bus.clr1;

    // Pointer only breaks ties; a lone eligible channel always wins.
    assign w_gnt0 = w_elig0 & (~w_elig1 | ~r_ptr);
    assign w_gnt1 = w_elig1 & ~w_gnt0;

    assign w_sel  = w_gnt1 ? r_cnt1 : r_cnt0;
    assign w_top0 = &r_cnt0;
    assign w_top1 = &r_cnt1;

    Inc4Bit u_inc (
        .a (w_sel),
        .b (w_inc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0  <= 4'd0;
            r_cnt1  <= 4'd0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_wrap0 <= 1'b0;
            r_wrap1 <= 1'b0;
            r_ptr   <= FIRST;
        end else begin
            r_ack0  <= w_gnt0;
            r_ack1  <= w_gnt1;
            r_wrap0 <= w_gnt0 & ~SAT & w_top0;
            r_wrap1 <= w_gnt1 & ~SAT & w_top1;

            if (bus.clr0)
                r_cnt0 <= 4'd0;
            else if (w_gnt0 && !(SAT && w_top0))
                r_cnt0 <= w_inc;

            if (bus.clr1)
                r_cnt1 <= 4'd0;
            else if (w_gnt1 && !(SAT && w_top1))
                r_cnt1 <= w_inc;

            if (w_gnt0)
                r_ptr <= 1'b1;
            else if (w_gnt1)
                r_ptr <= 1'b0;
        end
    end

    assign bus.cnt0  = r_cnt0;
    assign bus.cnt1  = r_cnt1;
    assign bus.ack0  = r_ack0;
    assign bus.ack1  = r_ack1;
    assign bus.wrap0 = r_wrap0;
    assign bus.wrap1 = r_wrap1;
    assign bus.busy  = w_elig0 | w_elig1;
endmodule

// File: tb/tb_inc_share_arbiter.sv
// Bench for inc_share_arbiter: two instances (wrap/FIRST=0, saturate/FIRST=1)
// share one stimulus stream and are checked against a per-instance count model.
module tb_inc_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic s_req0 = 1'b0;
    logic s_req1 = 1'b0;
    logic s_clr0 = 1'b0;
    logic s_clr1 = 1'b0;

    inc_share_arbiter_if if0();
    inc_share_arbiter_if if1();

    assign if0.req0 = s_req0;
    assign if0.req1 = s_req1;
    assign if0.clr0 = s_clr0;
    assign if0.clr1 = s_clr1;
    assign if1.req0 = s_req0;
    assign if1.req1 = s_req1;
    assign if1.clr0 = s_clr0;
    assign if1.clr1 = s_clr1;

    inc_share_arbiter #(.SAT(1'b0), .FIRST(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    inc_share_arbiter #(.SAT(1'b1), .FIRST(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    int checks = 0;
    int failures = 0;

    int m_cnt [2][2];
    int m_ack [2][2];
    int m_wrap[2][2];
    int m_ptr [2];
    int n_ack [2][2];
    int n_wrap[2][2];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int is_sat(int k);
        return (k == 1) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                m_cnt[k][c]  = 0;
                m_ack[k][c]  = 0;
                m_wrap[k][c] = 0;
            end
            m_ptr[k] = k;
        end
    endtask

    function automatic int elig(int k, int c);
        int r;
        int cl;
        r  = (c == 0) ? int'(s_req0) : int'(s_req1);
        cl = (c == 0) ? int'(s_clr0) : int'(s_clr1);
        return (r == 1 && m_ack[k][c] == 0 && cl == 0) ? 1 : 0;
    endfunction

    // One clock edge worth of the specified behaviour, for each instance.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int e0;
            int e1;
            int win;
            e0  = elig(k, 0);
            e1  = elig(k, 1);
            win = -1;
            if (e0 == 1 && e1 == 1)
                win = m_ptr[k];
            else if (e0 == 1)
                win = 0;
            else if (e1 == 1)
                win = 1;
            for (int c = 0; c < 2; c++) begin
                int cl;
                cl = (c == 0) ? int'(s_clr0) : int'(s_clr1);
                m_ack[k][c]  = (win == c) ? 1 : 0;
                m_wrap[k][c] = (win == c && is_sat(k) == 0 && m_cnt[k][c] == 15) ? 1 : 0;
                if (cl == 1)
                    m_cnt[k][c] = 0;
                else if (win == c) begin
                    if (is_sat(k) == 1 && m_cnt[k][c] == 15)
                        m_cnt[k][c] = 15;
                    else
                        m_cnt[k][c] = (m_cnt[k][c] + 1) % 16;
                end
            end
            if (win >= 0)
                m_ptr[k] = 1 - win;
        end
    endtask

    task automatic cmp_one(int k, int c0, int c1, int a0, int a1,
                           int w0, int w1, int b);
        chk($sformatf("cnt0_d%0d", k), c0, m_cnt[k][0]);
        chk($sformatf("cnt1_d%0d", k), c1, m_cnt[k][1]);
        chk($sformatf("ack0_d%0d", k), a0, m_ack[k][0]);
        chk($sformatf("ack1_d%0d", k), a1, m_ack[k][1]);
        chk($sformatf("wrap0_d%0d", k), w0, m_wrap[k][0]);
        chk($sformatf("wrap1_d%0d", k), w1, m_wrap[k][1]);
        chk($sformatf("busy_d%0d", k), b, (elig(k, 0) | elig(k, 1)));
        chk($sformatf("ack_excl_d%0d", k), a0 & a1, 0);
        if (w0 == 1) chk($sformatf("wrap0_cnt_d%0d", k), c0, 0);
        if (w1 == 1) chk($sformatf("wrap1_cnt_d%0d", k), c1, 0);
        n_ack[k][0]  += a0;
        n_ack[k][1]  += a1;
        n_wrap[k][0] += w0;
        n_wrap[k][1] += w1;
    endtask

    task automatic compare();
        cmp_one(0, int'(if0.cnt0), int'(if0.cnt1), int'(if0.ack0), int'(if0.ack1),
                int'(if0.wrap0), int'(if0.wrap1), int'(if0.busy));
        cmp_one(1, int'(if1.cnt0), int'(if1.cnt1), int'(if1.ack0), int'(if1.ack1),
                int'(if1.wrap0), int'(if1.wrap1), int'(if1.busy));
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++) begin
                n_ack[k][c]  = 0;
                n_wrap[k][c] = 0;
            end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(bit r0, bit r1, bit c0, bit c1);
        #1;
        s_req0 = r0;
        s_req1 = r1;
        s_clr0 = c0;
        s_clr1 = c1;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_cnt0", int'(if0.cnt0), 0);
        chk("rst_async_ack1", int'(if1.ack1), 0);
        compare();
        @(posedge clk);
        @(negedge clk);
        compare();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_update();
    endtask

    initial begin
        model_reset();
        clear_counts();
        repeat (2) @(negedge clk);
        compare();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_update();

        repeat (3) step(0, 0, 0, 0);
        #2;
        chk("idle_cnt0", int'(if0.cnt0), 0);
        chk("idle_cnt1", int'(if1.cnt1), 0);
        chk("idle_busy", int'(if0.busy), 0);

        // Single channel held: one increment every other cycle.
        clear_counts();
        repeat (32) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        #2;
        chk("single_acks", n_ack[0][0], 16);
        chk("single_wraps", n_wrap[0][0], 1);
        chk("single_cnt0", int'(if0.cnt0), 0);

        // Contention from reset: strict alternation.
        do_reset();
        repeat (4) step(1, 1, 0, 0);
        #2;
        chk("cont_cnt0_d0", int'(if0.cnt0), 2);
        chk("cont_cnt1_d0", int'(if0.cnt1), 2);
        chk("cont_cnt0_d1", int'(if1.cnt0), 2);
        chk("cont_cnt1_d1", int'(if1.cnt1), 2);
        step(0, 0, 0, 0);

        // Saturation on the SAT=1 instance.
        do_reset();
        clear_counts();
        repeat (32) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        #2;
        chk("sat_cnt1", int'(if1.cnt1), 15);
        chk("sat_acks", n_ack[1][1], 16);
        step(0, 1, 0, 0);
        #2;
        chk("sat_ack1", int'(if1.ack1), 1);
        chk("sat_hold", int'(if1.cnt1), 15);
        chk("sat_nowrap", int'(if1.wrap1), 0);

        // Clear colliding with a request.
        step(0, 0, 0, 0);
        do_reset();
        repeat (14) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        #2;
        chk("clr_pre_cnt0", int'(if0.cnt0), 7);
        step(1, 1, 1, 0);
        #2;
        chk("clr_cnt0", int'(if0.cnt0), 0);
        chk("clr_ack0", int'(if0.ack0), 0);
        chk("clr_ack1", int'(if0.ack1), 1);
        chk("clr_cnt1", int'(if0.cnt1), 1);
        step(1, 0, 0, 0);
        #2;
        chk("clr_post_cnt0", int'(if0.cnt0), 1);
        chk("clr_post_ack0", int'(if0.ack0), 1);

        // Reset in the middle of contention.
        repeat (5) step(1, 1, 0, 0);
        do_reset();
        #2;
        chk("rst_mid_ack0_d0", int'(if0.ack0), 1);
        chk("rst_mid_ack1_d0", int'(if0.ack1), 0);
        chk("rst_mid_ack1_d1", int'(if1.ack1), 1);
        chk("rst_mid_cnt0_d0", int'(if0.cnt0), 1);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0)
                do_reset();
        end
        step(0, 0, 0, 0);
        chk("sat_never_wraps", n_wrap[1][0] + n_wrap[1][1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
